// File: rtl/qq_pq_if.sv
// Command/status bundle of the qq_pq ordered buffer.
// The master side issues enqueue/dequeue commands; the slave side is the queue.
interface qq_pq_if #(
  parameter int KW = 32,
  parameter int PW = 8,
  parameter int D  = 8
) ();
  localparam int CW = $clog2(D + 1);

  logic          enq_i;
  logic          deq_i;
  logic [KW-1:0] key_i;
  logic [PW-1:0] data_i;
  logic          rdy;
  logic [KW-1:0] head_key_o;
  logic [PW-1:0] head_data_o;
  logic          deq_vld_o;
  logic [KW-1:0] deq_key_o;
  logic [PW-1:0] deq_data_o;
  logic [CW-1:0] count_o;
  logic          full;
  logic          empty;
  logic          ovf_o;
  logic          udf_o;

  modport master (
    output enq_i, deq_i, key_i, data_i,
    input  rdy, head_key_o, head_data_o, deq_vld_o, deq_key_o, deq_data_o,
    input  count_o, full, empty, ovf_o, udf_o
  );

  modport slave (
    input  enq_i, deq_i, key_i, data_i,
    output rdy, head_key_o, head_data_o, deq_vld_o, deq_key_o, deq_data_o,
    output count_o, full, empty, ovf_o, udf_o
  );
endinterface

// File: rtl/qq_pq.sv
// Sorted register-array priority queue: one index visited per cycle for
// enqueue (swap sweep), dequeue (shift) and replace (shift until insert point).
module qq_pq #(
  parameter int KW        = 32,
  parameter int PW        = 8,
  parameter int D         = 8,
  parameter bit MIN_FIRST = 1'b1
) (
  input logic     clk,
  input logic     rst,
  qq_pq_if.slave  bus
);
  localparam int CW = $clog2(D + 1);
  localparam int AW = $clog2(D);

  typedef enum logic [1:0] {S_IDLE, S_ENQ, S_DEQ, S_REPL} state_t;

  state_t        r_state, w_state_next;
  logic [KW-1:0] r_mem_key  [D];
  logic [PW-1:0] r_mem_data [D];
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [CW-1:0] r_i, w_i_next;
  logic [KW-1:0] r_t_key, w_t_key_next;
  logic [PW-1:0] r_t_data, w_t_data_next;
  logic [KW-1:0] r_deq_key, w_deq_key_next;
  logic [PW-1:0] r_deq_data, w_deq_data_next;
  logic          r_deq_vld, w_deq_vld_next;
  logic          r_ovf, w_ovf_next;
  logic          r_udf, w_udf_next;
  logic          r_full, w_full_next;
  logic          r_empty, w_empty_next;

  logic          w_wr_en;
  logic [KW-1:0] w_wr_key;
  logic [PW-1:0] w_wr_data;
  logic [CW-1:0] w_i1;
  logic [AW-1:0] w_idx, w_idx1;
  logic [KW-1:0] w_cur_key, w_nxt_key;
  logic [PW-1:0] w_cur_data, w_nxt_data;
  logic          w_last;

  // Strict compare: equal keys never overtake, which keeps equal keys FIFO.
  function automatic logic f_before(input logic [KW-1:0] a, input logic [KW-1:0] b);
    return MIN_FIRST ? (a < b) : (a > b);
  endfunction

  assign w_i1       = r_i + CW'(1);
  assign w_idx      = r_i[AW-1:0];
  assign w_idx1     = w_i1[AW-1:0];
  assign w_cur_key  = r_mem_key[w_idx];
  assign w_cur_data = r_mem_data[w_idx];
  assign w_nxt_key  = r_mem_key[w_idx1];
  assign w_nxt_data = r_mem_data[w_idx1];
  assign w_last     = (r_i == r_cnt - CW'(1));

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_i_next        = r_i;
    w_t_key_next    = r_t_key;
    w_t_data_next   = r_t_data;
    w_deq_key_next  = r_deq_key;
    w_deq_data_next = r_deq_data;
    w_deq_vld_next  = 1'b0;
    w_ovf_next      = 1'b0;
    w_udf_next      = 1'b0;
    w_full_next     = r_full;
    w_empty_next    = r_empty;
    w_wr_en         = 1'b0;
    w_wr_key        = r_t_key;
    w_wr_data       = r_t_data;
    case (r_state)
      S_IDLE: begin
        w_i_next = '0;
        if (bus.deq_i && (r_cnt != '0)) begin
          w_deq_key_next  = r_mem_key[0];
          w_deq_data_next = r_mem_data[0];
          w_deq_vld_next  = 1'b1;
          if (bus.enq_i) begin
            w_t_key_next  = bus.key_i;
            w_t_data_next = bus.data_i;
            w_state_next  = S_REPL;
          end else begin
            w_state_next  = S_DEQ;
          end
        end else begin
          // Dequeue on empty flags underflow; a paired enqueue still proceeds.
          if (bus.deq_i) w_udf_next = 1'b1;
          if (bus.enq_i) begin
            if (r_cnt == CW'(D)) begin
              w_ovf_next = 1'b1;
            end else begin
              w_t_key_next  = bus.key_i;
              w_t_data_next = bus.data_i;
              w_state_next  = S_ENQ;
            end
          end
        end
      end
      S_ENQ: begin
        if (r_i == r_cnt) begin
          w_wr_en      = 1'b1;
          w_cnt_next   = r_cnt + CW'(1);
          w_full_next  = ((r_cnt + CW'(1)) == CW'(D));
          w_empty_next = 1'b0;
          w_state_next = S_IDLE;
        end else begin
          if (f_before(r_t_key, w_cur_key)) begin
            w_wr_en       = 1'b1;
            w_t_key_next  = w_cur_key;
            w_t_data_next = w_cur_data;
          end
          w_i_next = w_i1;
        end
      end
      S_DEQ: begin
        if (r_cnt != CW'(1)) begin
          w_wr_en   = 1'b1;
          w_wr_key  = w_nxt_key;
          w_wr_data = w_nxt_data;
        end
        if ((r_cnt == CW'(1)) || (r_i == r_cnt - CW'(2))) begin
          w_cnt_next   = r_cnt - CW'(1);
          w_full_next  = 1'b0;
          w_empty_next = (r_cnt == CW'(1));
          w_state_next = S_IDLE;
        end else begin
          w_i_next = w_i1;
        end
      end
      S_REPL: begin
        w_wr_en = 1'b1;
        if (w_last || f_before(r_t_key, w_nxt_key)) begin
          w_state_next = S_IDLE;
        end else begin
          w_wr_key  = w_nxt_key;
          w_wr_data = w_nxt_data;
          w_i_next  = w_i1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_i        <= '0;
      r_t_key    <= '0;
      r_t_data   <= '0;
      r_deq_key  <= '0;
      r_deq_data <= '0;
      r_deq_vld  <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      for (int k = 0; k < D; k++) begin
        r_mem_key[k]  <= '0;
        r_mem_data[k] <= '0;
      end
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_i        <= w_i_next;
      r_t_key    <= w_t_key_next;
      r_t_data   <= w_t_data_next;
      r_deq_key  <= w_deq_key_next;
      r_deq_data <= w_deq_data_next;
      r_deq_vld  <= w_deq_vld_next;
      r_ovf      <= w_ovf_next;
      r_udf      <= w_udf_next;
      r_full     <= w_full_next;
      r_empty    <= w_empty_next;
      if (w_wr_en) begin
        r_mem_key[w_idx]  <= w_wr_key;
        r_mem_data[w_idx] <= w_wr_data;
      end
    end
  end

  assign bus.rdy         = (r_state == S_IDLE);
  assign bus.head_key_o  = r_mem_key[0];
  assign bus.head_data_o = r_mem_data[0];
  assign bus.deq_vld_o   = r_deq_vld;
  assign bus.deq_key_o   = r_deq_key;
  assign bus.deq_data_o  = r_deq_data;
  assign bus.count_o     = r_cnt;
  assign bus.full        = r_full;
  assign bus.empty       = r_empty;
  assign bus.ovf_o       = r_ovf;
  assign bus.udf_o       = r_udf;
endmodule

// File: tb/tb_qq_pq.sv
// Bench for qq_pq: a min-first and a max-first instance share one stimulus
// stream and are each compared every cycle against an array-based queue model.
module tb_qq_pq;
  localparam int KW = 32;
  localparam int PW = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          enq  = 1'b0;
  logic          deq  = 1'b0;
  logic [KW-1:0] key  = '0;
  logic [PW-1:0] data = '0;

  qq_pq_if #(.KW(KW), .PW(PW), .D(D)) bus0 ();
  qq_pq_if #(.KW(KW), .PW(PW), .D(D)) bus1 ();

  assign bus0.enq_i = enq;  assign bus1.enq_i = enq;
  assign bus0.deq_i = deq;  assign bus1.deq_i = deq;
  assign bus0.key_i = key;  assign bus1.key_i = key;
  assign bus0.data_i = data; assign bus1.data_i = data;

  qq_pq #(.KW(KW), .PW(PW), .D(D), .MIN_FIRST(1'b1)) u_min (.clk(clk), .rst(rst), .bus(bus0));
  qq_pq #(.KW(KW), .PW(PW), .D(D), .MIN_FIRST(1'b0)) u_max (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (lane 0 = min-first, 1 = max-first)
  logic [KW-1:0] mk [2][D];
  logic [PW-1:0] md [2][D];
  int            mn   [2];
  int            busy [2];
  bit            hz   [2];
  bit            e_vld [2];
  bit            e_ovf [2];
  bit            e_udf [2];
  logic [KW-1:0] e_dk  [2];
  logic [PW-1:0] e_dd  [2];

  function automatic bit bef(input int l, input logic [KW-1:0] a, input logic [KW-1:0] b);
    return (l == 0) ? (a < b) : (a > b);
  endfunction

  task automatic model_reset(input int l);
    mn[l] = 0; busy[l] = 0; hz[l] = 1'b1;
    e_vld[l] = 1'b0; e_ovf[l] = 1'b0; e_udf[l] = 1'b0;
  endtask

  task automatic model_step(input int l, input bit e, input bit d,
                            input logic [KW-1:0] k, input logic [PW-1:0] dt);
    int n, p;
    bit found;
    logic [KW-1:0] tk, sk;
    logic [PW-1:0] td, sd;
    e_vld[l] = 1'b0; e_ovf[l] = 1'b0; e_udf[l] = 1'b0;
    if (busy[l] > 0) begin
      busy[l]--;
      return;
    end
    if (!e && !d) return;
    n = mn[l];
    if (d && n > 0) begin
      e_vld[l] = 1'b1; e_dk[l] = mk[l][0]; e_dd[l] = md[l][0];
      for (int j = 0; j < n - 1; j++) begin
        mk[l][j] = mk[l][j+1]; md[l][j] = md[l][j+1];
      end
      if (e) begin
        p = n - 1; found = 1'b0;
        for (int j = 0; j < n - 1; j++)
          if (!found && bef(l, k, mk[l][j])) begin p = j; found = 1'b1; end
        for (int j = n - 1; j > p; j--) begin
          mk[l][j] = mk[l][j-1]; md[l][j] = md[l][j-1];
        end
        mk[l][p] = k; md[l][p] = dt;
        busy[l] = p + 1; hz[l] = 1'b0;
      end else begin
        mn[l] = n - 1;
        busy[l] = (n > 1) ? n - 1 : 1;
      end
    end else begin
      if (d) e_udf[l] = 1'b1;
      if (e) begin
        if (n == D) begin
          e_ovf[l] = 1'b1;
        end else begin
          tk = k; td = dt;
          for (int j = 0; j < n; j++)
            if (bef(l, tk, mk[l][j])) begin
              sk = mk[l][j]; sd = md[l][j];
              mk[l][j] = tk; md[l][j] = td;
              tk = sk; td = sd;
            end
          mk[l][n] = tk; md[l][n] = td;
          mn[l] = n + 1; busy[l] = n + 1; hz[l] = 1'b0;
        end
      end
    end
  endtask

  task automatic lane_check(input int l, input logic rdy, input logic vld,
                            input logic [KW-1:0] dk, input logic [PW-1:0] dd,
                            input logic [CW-1:0] cnt, input logic fu, input logic em,
                            input logic ov, input logic ud,
                            input logic [KW-1:0] hk, input logic [PW-1:0] hd);
    string pre;
    pre = (l == 0) ? "min" : "max";
    chk({pre, ".rdy"}, 64'(rdy), 64'(busy[l] == 0));
    chk({pre, ".deq_vld"}, 64'(vld), 64'(e_vld[l]));
    chk({pre, ".ovf"}, 64'(ov), 64'(e_ovf[l]));
    chk({pre, ".udf"}, 64'(ud), 64'(e_udf[l]));
    if (e_vld[l]) begin
      chk({pre, ".deq_key"}, 64'(dk), 64'(e_dk[l]));
      chk({pre, ".deq_data"}, 64'(dd), 64'(e_dd[l]));
    end
    if (busy[l] == 0) begin
      chk({pre, ".count"}, 64'(cnt), 64'(mn[l]));
      chk({pre, ".full"}, 64'(fu), 64'(mn[l] == D));
      chk({pre, ".empty"}, 64'(em), 64'(mn[l] == 0));
      if (mn[l] > 0) begin
        chk({pre, ".head_key"}, 64'(hk), 64'(mk[l][0]));
        chk({pre, ".head_data"}, 64'(hd), 64'(md[l][0]));
      end else if (hz[l]) begin
        chk({pre, ".head_key0"}, 64'(hk), 64'(0));
        chk({pre, ".head_data0"}, 64'(hd), 64'(0));
      end
    end
  endtask

  // Model advances on the edge that samples inputs; outputs checked mid-cycle.
  initial begin
    forever begin
      @(posedge clk);
      for (int l = 0; l < 2; l++) begin
        if (rst) model_reset(l);
        else     model_step(l, enq, deq, key, data);
      end
      @(negedge clk);
      lane_check(0, bus0.rdy, bus0.deq_vld_o, bus0.deq_key_o, bus0.deq_data_o, bus0.count_o,
                 bus0.full, bus0.empty, bus0.ovf_o, bus0.udf_o, bus0.head_key_o, bus0.head_data_o);
      lane_check(1, bus1.rdy, bus1.deq_vld_o, bus1.deq_key_o, bus1.deq_data_o, bus1.count_o,
                 bus1.full, bus1.empty, bus1.ovf_o, bus1.udf_o, bus1.head_key_o, bus1.head_data_o);
    end
  end

  // ---------------- directed helpers (always entered and left on a negedge)
  task automatic idle_wait();
    int t;
    t = 0;
    while ((busy[0] != 0 || busy[1] != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_errors++;
      $display("FAIL idle_timeout: model still busy after %0d cycles", t);
    end
  endtask

  task automatic cmd(input bit e, input bit d, input logic [KW-1:0] k, input logic [PW-1:0] dt);
    idle_wait();
    enq = e; deq = d; key = k; data = dt;
    $display("tb: cmd enq=%0d deq=%0d key=%0d data=%02h count_min=%0d", e, d, k, dt, mn[0]);
    @(negedge clk);
    enq = 1'b0; deq = 1'b0;
  endtask

  task automatic low_cycles(output int n);
    n = 0;
    while (bus0.rdy !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lc;
    int ek [4];
    int ed [4];

    // Reset: two cycles high
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.rdy", 64'(bus0.rdy), 64'(1));
    chk("rst.empty", 64'(bus0.empty), 64'(1));
    chk("rst.full", 64'(bus0.full), 64'(0));
    chk("rst.count", 64'(bus0.count_o), 64'(0));
    chk("rst.pulses", 64'({bus0.deq_vld_o, bus0.ovf_o, bus0.udf_o}), 64'(0));
    chk("rst.head_key", 64'(bus0.head_key_o), 64'(0));
    chk("rst.deq_key", 64'(bus0.deq_key_o), 64'(0));

    // Fill, overflow, drain
    cmd(1, 0, 5, 8'h0A); cmd(1, 0, 3, 8'h0B); cmd(1, 0, 9, 8'h0C); cmd(1, 0, 3, 8'h0D);
    idle_wait();
    chk("fill.head_key", 64'(bus0.head_key_o), 64'(3));
    chk("fill.head_data", 64'(bus0.head_data_o), 64'(8'h0B));
    chk("fill.full", 64'(bus0.full), 64'(1));
    cmd(1, 0, 7, 8'h7E);
    chk("ovf.pulse", 64'(bus0.ovf_o), 64'(1));
    chk("ovf.rdy", 64'(bus0.rdy), 64'(1));
    chk("ovf.count", 64'(bus0.count_o), 64'(4));
    ek = '{3, 3, 5, 9};
    ed = '{8'h0B, 8'h0D, 8'h0A, 8'h0C};
    for (int j = 0; j < 4; j++) begin
      cmd(0, 1, 0, 0);
      chk("drain.vld", 64'(bus0.deq_vld_o), 64'(1));
      chk("drain.key", 64'(bus0.deq_key_o), 64'(ek[j]));
      chk("drain.data", 64'(bus0.deq_data_o), 64'(ed[j]));
    end
    idle_wait();
    chk("drain.empty", 64'(bus0.empty), 64'(1));

    // Underflow
    cmd(0, 1, 0, 0);
    chk("udf.pulse", 64'(bus0.udf_o), 64'(1));
    chk("udf.vld", 64'(bus0.deq_vld_o), 64'(0));
    chk("udf.rdy", 64'(bus0.rdy), 64'(1));
    @(negedge clk);
    chk("udf.one_cycle", 64'(bus0.udf_o), 64'(0));

    // Replace on a full queue
    cmd(1, 0, 1, 8'h11); cmd(1, 0, 4, 8'h44); cmd(1, 0, 6, 8'h66); cmd(1, 0, 8, 8'h88);
    cmd(1, 1, 5, 8'h55);
    chk("repl5.key", 64'(bus0.deq_key_o), 64'(1));
    low_cycles(lc);
    chk("repl5.busy", 64'(lc), 64'(2));
    idle_wait();
    chk("repl5.head", 64'(bus0.head_key_o), 64'(4));
    cmd(1, 1, 9, 8'h99);
    chk("repl9.key", 64'(bus0.deq_key_o), 64'(4));
    low_cycles(lc);
    chk("repl9.busy", 64'(lc), 64'(4));
    ek = '{5, 6, 8, 9};
    for (int j = 0; j < 4; j++) begin
      cmd(0, 1, 0, 0);
      chk("repl.drain", 64'(bus0.deq_key_o), 64'(ek[j]));
    end

    // Max-first with equal keys
    cmd(1, 0, 2, 8'h58); cmd(1, 0, 7, 8'h59); cmd(1, 0, 7, 8'h5A);
    ek = '{7, 7, 2, 0};
    ed = '{8'h59, 8'h5A, 8'h58, 0};
    for (int j = 0; j < 3; j++) begin
      cmd(0, 1, 0, 0);
      chk("maxq.key", 64'(bus1.deq_key_o), 64'(ek[j]));
      chk("maxq.data", 64'(bus1.deq_data_o), 64'(ed[j]));
    end

    // Enqueue latency at count 3, then reset inside an enqueue
    cmd(1, 0, 1, 8'h01); cmd(1, 0, 2, 8'h02); cmd(1, 0, 3, 8'h03);
    cmd(1, 0, 10, 8'h10);
    low_cycles(lc);
    chk("enq3.busy", 64'(lc), 64'(4));
    cmd(0, 1, 0, 0);
    cmd(1, 0, 11, 8'h20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.rdy", 64'(bus0.rdy), 64'(1));
    chk("midrst.empty", 64'(bus0.empty), 64'(1));
    chk("midrst.head", 64'(bus0.head_key_o), 64'(0));
    rst = 1'b0;

    // Randomized phases with varying enqueue/dequeue pressure
    for (int ph = 0; ph < 10; ph++) begin
      int pe, pd;
      pe = $urandom_range(20, 85);
      pd = $urandom_range(10, 70);
      $display("tb: random phase %0d enq%%=%0d deq%%=%0d", ph, pe, pd);
      for (int c = 0; c < 300; c++) begin
        enq  = ($urandom_range(0, 99) < pe);
        deq  = ($urandom_range(0, 99) < pd);
        key  = ($urandom_range(0, 3) == 0) ? KW'($urandom) : KW'($urandom_range(0, 9));
        data = PW'($urandom);
        rst  = ($urandom_range(0, 499) == 0);
        @(negedge clk);
      end
    end
    enq = 1'b0; deq = 1'b0; rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/qq_pq.md
# qq_pq

Parametrised single-node priority queue for QuickQ v3: sorted register storage of `D` key+payload entries, with its own controller and datapath. It supports enqueue, dequeue and a combined replace (pop head + insert) operation. Ordering is selectable (min-first or max-first), and ordering among equal keys is stable (FIFO). It sits behind the scheduler's command port as a drop-in ordered buffer, and it reports occupancy and error pulses.

## Interface
- `KW`, 32: key width (unsigned compare)
- `PW`, 8: payload width
- `D`, 8: depth in entries, ≥ 2
- `MIN_FIRST`, 1: 1 = smallest key at head; 0 = largest key at head
- `clk` in 1: single clock; all state changes on the rising edge
- `rst` in 1: reset, synchronous, active-high
- `enq_i` in 1: enqueue request, sampled only when `rdy`=1
- `deq_i` in 1: dequeue request, sampled only when `rdy`=1
- `key_i` in KW: key to insert
- `data_i` in PW: payload to insert
- `rdy` out 1: idle, accepting a command
- `head_key_o` out KW: entry 0 key, continuous
- `head_data_o` out PW: entry 0 payload, continuous
- `deq_vld_o` out 1: one-cycle pulse, popped item valid
- `deq_key_o` out KW: popped key, registered
- `deq_data_o` out PW: popped payload, registered
- `count_o` out $clog2(D+1): number of valid entries
- `full` out 1: `count_o`==D
- `empty` out 1: `count_o`==0
- `ovf_o` out 1: one-cycle pulse, enqueue rejected because full
- `udf_o` out 1: one-cycle pulse, dequeue rejected because empty

## Operation
- Storage is `mem[0..D-1]` of {key, payload}. Entries at index ≥ count are don't-care.
- `before(a,b)`: a<b if `MIN_FIRST`, else a>b. It is strict, which is what makes ordering stable.
- States are IDLE, ENQ, DEQ and REPL. Command decode happens only in IDLE, with n = count at decode. Requests arriving while `rdy`=0 are ignored, with no flags.
  - **enq only, not full:** t ← {key_i, data_i}, i ← 0, go to ENQ.
  - **enq only, full:** pulse `ovf_o`, stay in IDLE, no change.
  - **deq only, empty:** pulse `udf_o`, stay in IDLE.
  - **deq only, n > 0:** latch mem[0] into `deq_*`, pulse `deq_vld_o`, go to DEQ.
  - **enq and deq, n > 0 (full allowed):** latch mem[0] into `deq_*`, pulse `deq_vld_o`, t ← input, i ← 0, go to REPL.
  - **enq and deq, empty:** pulse `udf_o` and perform an enqueue only.
- **ENQ** visits one index per cycle, i = 0..n:
  - For i<n: if before(t.key, mem[i].key), write t to mem[i] and set t ← mem[i] (swap); otherwise no write.
  - At i=n: write t, count ← n+1, go to IDLE.
- **DEQ**: mem[i] ← mem[i+1] for i = 0..n-2, one index per cycle. On the last cycle, count ← n-1 and go to IDLE. When n=1 there is a single cycle with no shift.
- **REPL** visits one index per cycle, i = 0..n-1:
  - If i==n-1 or before(t.key, mem[i+1].key): write t to mem[i], go to IDLE.
  - Otherwise: mem[i] ← mem[i+1].
  - count is unchanged.
- `full`, `empty` and `count_o` are registered and update on the IDLE return.
- **Reset (also mid-operation):** state→IDLE, all mem cleared to 0, count 0. Reset values:
  - `rdy`=1, `empty`=1
  - `full`, `deq_vld_o`, `ovf_o`, `udf_o` = 0
  - `deq_key_o`, `deq_data_o`, `head_*` = 0
  - Any in-flight operation is discarded.

## Timing
- Command accepted at cycle c with n entries. Latency to `rdy` high again:
  - ENQ: c+n+2 (n+1 ENQ cycles).
  - DEQ: c+max(n-1,1)+1.
  - REPL: c+k+1, where k = final i+1 (1..n).
  - ovf/udf: no busy cycles; `rdy` stays 1 and the pulse appears at c+1.
- `deq_vld_o` and `deq_key_o`/`deq_data_o` become valid at c+1 for one cycle.
- `count_o`, `full`, `empty` and `head_*` reflect the new contents in the same cycle `rdy` returns to 1.
- Back-to-back commands are allowed: a new command may be issued in the first cycle `rdy`=1.

## Test plan
- **Reset:** assert `rst` 2 cycles → next cycle `rdy`=1, `empty`=1, `count_o`=0, all pulses 0.
- **Fill, overflow, drain:** D=4, MIN_FIRST=1. Enqueue (5,A),(3,B),(9,C),(3,D) → `head`=3/B, `full`=1. Enqueue 7 → `ovf_o` pulse, `count_o` stays 4. Four dequeues → `deq_*` = 3/B, 3/D, 5/A, 9/C, then `empty`=1.
- **Underflow:** deq on empty → `udf_o` 1 cycle at c+1, `deq_vld_o`=0, `rdy` never drops.
- **Replace:** full queue {1,4,6,8}.
  - REPL key 5 → pops 1, queue {4,5,6,8}, `rdy` low 2 cycles.
  - REPL key 9 on {4,5,6,8} → pops 4, queue {5,6,8,9}, `rdy` low 4 cycles.
- **Max-first and equal keys:** MIN_FIRST=0, enqueue (2,X),(7,Y),(7,Z) → dequeues give 7/Y, 7/Z, 2/X.
- **Latency and reset mid-operation:** enqueue with `count_o`=3 → `rdy` low exactly 4 cycles. Assert `rst` during the 2nd ENQ cycle → next cycle `rdy`=1, `empty`=1, `head_key_o`=0.
